stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
- Consumes the divided slow clock level produced by the slow-clock divider stage.
- Synchronizes it into the clk domain and turns each rising edge into a one-cycle tick.
- Uses the ticks to run an mm:ss BCD stopwatch with start/stop/clear control and a programmable alarm.
- Outputs feed the 7-segment/LED display logic on the Tang Nano board.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on slow_clk; minimum 2.
- MAX_MINUTES, 59, largest minute value before wrap to 00:00; integer 0..99.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- slow_clk  in  1  divider output level; any duty cycle; each rising edge is one second.
- start  in  1  one-cycle command pulse.
- stop  in  1  one-cycle command pulse.
- clear  in  1  one-cycle command pulse.
- alarm_en  in  1  enables alarm compare (level).
- alarm_mm  in  8  alarm minutes, two BCD digits.
- alarm_ss  in  8  alarm seconds, two BCD digits.
- min_bcd  out  8  minutes, [7:4] tens, [3:0] units.
- sec_bcd  out  8  seconds, [7:4] tens, [3:0] units.
- tick  out  1  registered one-cycle pulse per detected slow_clk rising edge.
- running  out  1  high in RUN state.
- alarm  out  1  high in ALARM state.
- overflow  out  1  one-cycle pulse on wrap past MAX_MINUTES:59.

Behaviour:
- Reset values (rst_n low, asynchronous): all outputs 0, count 00:00, state IDLE, synchronizer chain and edge-history flop 0.
- Edge detect:
  - slow_clk passes through SYNC_STAGES flops, then a history flop.
  - An edge is detected when the synced value is 1 and the history value is 0.
  - tick rises exactly SYNC_STAGES+1 clk edges after the first clk edge that samples slow_clk high.
  - Count updates on the same clk edge that sets tick.
- Start-up guard: edge detection is disabled for the first SYNC_STAGES+1 clk cycles after rst_n deasserts. slow_clk held high through reset release produces no tick.
- tick pulses in every state; only RUN consumes it.
- Command priority in the same cycle: clear > stop > start.
- IDLE (count 00:00):
  - start -> RUN.
  - stop and clear have no effect.
- RUN:
  - clear -> IDLE, count 00:00.
  - stop -> PAUSE; a tick in the same cycle is discarded and the count is unchanged.
  - Otherwise, on a tick the count increments:
    - Seconds BCD 59 -> 00 with a carry into minutes.
    - Minutes BCD increment.
    - At MAX_MINUTES:59 the count wraps to 00:00 and overflow pulses for 1 cycle.
  - After an increment, if alarm_en=1 and the new count equals alarm_mm:alarm_ss -> ALARM.
  - The compare uses the post-increment value and is evaluated on tick cycles only; changing alarm inputs never triggers the alarm by itself.
- PAUSE:
  - Count held.
  - start -> RUN.
  - clear -> IDLE, count 00:00.
- ALARM:
  - Count frozen; alarm=1; ticks ignored.
  - start -> RUN; alarm drops; counting resumes on the next tick.
  - stop -> PAUSE.
  - clear -> IDLE, count 00:00.
- Alarm values that are not valid BCD or exceed MAX_MINUTES:59 never match, so no alarm fires.
- An alarm of 00:00 matches only on wrap; overflow and the ALARM entry occur in the same cycle.
- running is 1 iff state is RUN. alarm is 1 iff state is ALARM. Both are registered and change on the transition edge.
- The count never holds non-BCD digit values.
- rst_n asserted in any state immediately returns all registers to reset values.

Test Plan:
- Tick latency: hold rst_n low, then release; raise slow_clk 10 cycles later -> tick high for exactly 1 cycle, SYNC_STAGES+1 (=3) clk edges after the first sampling edge; no further tick while slow_clk stays high.
- Start-up guard: slow_clk held high through reset release -> no tick; next 0->1 edge produces tick.
- Counting and wrap: start, then 60 ticks -> min_bcd=0x01, sec_bcd=0x00. With MAX_MINUTES=1 and 120 ticks -> count 00:00, overflow pulses once.
- Commands: after 5 ticks, pulse stop on a tick cycle -> count stays 00:05 and state is PAUSE (running=0). start, then 1 tick -> 00:06. start+stop+clear in one cycle -> IDLE, 00:00.
- Alarm: alarm_mm=0x00, alarm_ss=0x03, alarm_en=1, start, 3 ticks -> alarm=1 and count frozen at 00:03 through 2 further ticks; start -> alarm=0; next tick -> 00:04. With alarm_ss=0x3A, no alarm after 100 ticks.
- Mid-run reset: assert rst_n low during RUN at 00:17 -> outputs 0 asynchronously, before the next clk edge; after release, state is IDLE and ticks do not count until start.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// mm:ss BCD stopwatch driven by an externally divided slow clock level.
// slow_clk is synchronized, edge-detected into a one-cycle tick, and counted under start/stop/clear control.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | count held at 00:00, waiting for start
// RUN   | counting one second per tick
// PAUSE | count held, start resumes
// ALARM | count frozen at the alarm value, alarm high
module stopwatch_bcd #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_MINUTES = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       slow_clk,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       alarm_en,
   input  logic [7:0] alarm_mm,
   input  logic [7:0] alarm_ss,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       tick,
   output logic       running,
   output logic       alarm,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      ALARM = 2'd3
   } state_t;

   localparam int GW = $clog2(SYNC_STAGES + 2);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(SYNC_STAGES + 1);
   localparam logic [7:0] MAX_MM_BCD = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10)};

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;
   logic                   edge_q;
   logic [GW-1:0]          guard_cnt;
   logic                   guard_done;

   state_t     state, state_nxt;
   logic [7:0] min_nxt, sec_nxt;
   logic [7:0] min_inc, sec_inc;
   logic       wrap;
   logic       ovf_nxt;
   logic       alarm_hit;

   // Down-counter masks edge detection until the chain has flushed after reset.
   assign guard_done = (guard_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync      <= '0;
         hist      <= 1'b0;
         edge_q    <= 1'b0;
         tick      <= 1'b0;
         guard_cnt <= GUARD_LOAD;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], slow_clk};
         hist      <= sync[SYNC_STAGES-1];
         edge_q    <= sync[SYNC_STAGES-1] & ~hist & guard_done;
         tick      <= edge_q;
         if (!guard_done)
            guard_cnt <= guard_cnt - 1'b1;
      end
   end

   always_comb begin
      sec_inc = sec_bcd;
      min_inc = min_bcd;
      wrap    = 1'b0;
      if (sec_bcd[3:0] != 4'd9) begin
         sec_inc[3:0] = sec_bcd[3:0] + 4'd1;
      end else begin
         sec_inc[3:0] = 4'd0;
         if (sec_bcd[7:4] != 4'd5) begin
            sec_inc[7:4] = sec_bcd[7:4] + 4'd1;
         end else begin
            sec_inc[7:4] = 4'd0;
            if (min_bcd == MAX_MM_BCD) begin
               min_inc = 8'h00;
               wrap    = 1'b1;
            end else if (min_bcd[3:0] != 4'd9) begin
               min_inc[3:0] = min_bcd[3:0] + 4'd1;
            end else begin
               min_inc[3:0] = 4'd0;
               min_inc[7:4] = min_bcd[7:4] + 4'd1;
            end
         end
      end
   end

   // The count only ever holds valid in-range BCD, so malformed alarm values can never compare equal.
   assign alarm_hit = alarm_en && ({min_inc, sec_inc} == {alarm_mm, alarm_ss});

   always_comb begin
      state_nxt = state;
      min_nxt   = min_bcd;
      sec_nxt   = sec_bcd;
      ovf_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (clear || stop)
               state_nxt = IDLE;
            else if (start)
               state_nxt = RUN;
         end
         RUN: begin
            if (clear) begin
               state_nxt = IDLE;
               min_nxt   = 8'h00;
               sec_nxt   = 8'h00;
            end else if (stop) begin
               state_nxt = PAUSE;
            end else if (edge_q) begin
               min_nxt = min_inc;
               sec_nxt = sec_inc;
               ovf_nxt = wrap;
               if (alarm_hit)
                  state_nxt = ALARM;
            end
         end
         PAUSE, ALARM: begin
            if (clear) begin
               state_nxt = IDLE;
               min_nxt   = 8'h00;
               sec_nxt   = 8'h00;
            end else if (stop) begin
               state_nxt = PAUSE;
            end else if (start) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         overflow <= 1'b0;
         running  <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         state    <= state_nxt;
         min_bcd  <= min_nxt;
         sec_bcd  <= sec_nxt;
         overflow <= ovf_nxt;
         running  <= (state_nxt == RUN);
         alarm    <= (state_nxt == ALARM);
      end
   end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: default instance plus a MAX_MINUTES=1 instance sharing stimulus.
module tb_stopwatch_bcd;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       slow_clk;
   logic       start, stop, clear, alarm_en;
   logic [7:0] alarm_mm, alarm_ss;

   logic [7:0] min0, sec0, min1, sec1;
   logic       tick0, run0, alm0, ovf0;
   logic       tick1, run1, alm1, ovf1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_tick0  = 0;
   int n_ovf0   = 0;
   int n_ovf1   = 0;
   int snap_t, snap_o0, snap_o1;

   always #5 clk = ~clk;

   stopwatch_bcd dut0 (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk),
      .start(start), .stop(stop), .clear(clear),
      .alarm_en(alarm_en), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
      .min_bcd(min0), .sec_bcd(sec0), .tick(tick0),
      .running(run0), .alarm(alm0), .overflow(ovf0)
   );

   stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MINUTES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk),
      .start(start), .stop(stop), .clear(clear),
      .alarm_en(alarm_en), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
      .min_bcd(min1), .sec_bcd(sec1), .tick(tick1),
      .running(run1), .alarm(alm1), .overflow(ovf1)
   );

   always @(negedge clk) begin
      if (tick0) n_tick0 <= n_tick0 + 1;
      if (ovf0)  n_ovf0  <= n_ovf0 + 1;
      if (ovf1)  n_ovf1  <= n_ovf1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic one_tick();
      slow_clk = 1'b1;
      cyc(4);
      slow_clk = 1'b0;
      cyc(4);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) one_tick();
   endtask

   task automatic cmd(input logic s, input logic p, input logic c);
      start = s; stop = p; clear = c;
      cyc(1);
      start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; slow_clk = 1'b1;
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      alarm_en = 1'b0; alarm_mm = 8'h00; alarm_ss = 8'h00;
      cyc(3);
      chk("reset_count", {min0, sec0}, 16'h0000);
      chk("reset_flags", {tick0, run0, alm0, ovf0}, 4'b0000);

      // slow_clk high across reset release must not tick
      rst_n = 1'b1;
      cyc(10);
      chk("guard_no_tick", n_tick0, 0);

      slow_clk = 1'b0;
      cyc(4);
      slow_clk = 1'b1;
      cyc(1); chk("lat_e0", tick0, 1'b0);
      cyc(1); chk("lat_e1", tick0, 1'b0);
      cyc(1); chk("lat_e2", tick0, 1'b0);
      cyc(1); chk("lat_e3", {tick0, tick1}, 2'b11);
      cyc(1); chk("lat_e4", tick0, 1'b0);
      cyc(6);
      chk("lat_single", n_tick0, 1);
      chk("idle_ignores_tick", {run0, min0, sec0}, 17'h0_0000);
      slow_clk = 1'b0;
      cyc(4);

      // counting and wrap
      cmd(1, 0, 0);
      chk("start_running", {run0, run1}, 2'b11);
      snap_o0 = n_ovf0; snap_o1 = n_ovf1;
      ticks(60);
      chk("cnt60_d0", {min0, sec0}, 16'h0100);
      chk("cnt60_d1", {min1, sec1}, 16'h0100);
      ticks(60);
      chk("cnt120_d0", {min0, sec0}, 16'h0200);
      chk("wrap_d1", {min1, sec1}, 16'h0000);
      chk("ovf_d1_once", n_ovf1 - snap_o1, 1);
      chk("ovf_d0_none", n_ovf0 - snap_o0, 0);

      // commands
      cmd(0, 0, 1);
      chk("clear_idle", {run0, min0, sec0}, 17'h0_0000);
      cmd(1, 0, 0);
      ticks(5);
      chk("five_ticks", {min0, sec0}, 16'h0005);
      snap_t = n_tick0;
      slow_clk = 1'b1;
      cyc(3);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("stop_on_tick_pulse", tick0, 1'b1);
      chk("stop_on_tick_count", {run0, min0, sec0}, 17'h0_0005);
      cyc(3);
      slow_clk = 1'b0;
      cyc(4);
      one_tick();
      chk("pause_hold", {min0, sec0}, 16'h0005);
      chk("tick_in_pause", n_tick0 - snap_t, 2);
      cmd(1, 0, 0);
      one_tick();
      chk("resume_count", {run0, min0, sec0}, 17'h1_0006);
      cmd(1, 1, 1);
      chk("all_cmds_clear", {run0, alm0, min0, sec0}, 18'h0_0000);

      // alarm at 00:03
      alarm_en = 1'b1; alarm_mm = 8'h00; alarm_ss = 8'h03;
      cmd(1, 0, 0);
      ticks(3);
      chk("alarm_hit", {alm0, run0, min0, sec0}, 18'h2_0003);
      ticks(2);
      chk("alarm_frozen", {alm0, alm1, min0, sec0}, 18'h3_0003);
      cmd(1, 0, 0);
      chk("alarm_restart", {alm0, run0}, 2'b01);
      one_tick();
      chk("alarm_resume", {min0, sec0}, 16'h0004);

      // non-BCD alarm never fires
      cmd(0, 0, 1);
      alarm_ss = 8'h3A;
      cmd(1, 0, 0);
      ticks(100);
      chk("bad_alarm_none", {alm0, run0, min0, sec0}, 18'h1_0140);

      // alarm 00:00 fires only on wrap, together with overflow
      cmd(0, 0, 1);
      alarm_ss = 8'h00;
      cmd(1, 0, 0);
      snap_o1 = n_ovf1;
      ticks(119);
      chk("zero_alarm_pre", {alm1, min1, sec1}, 17'h0_0159);
      ticks(1);
      chk("zero_alarm_wrap", {alm1, run1, min1, sec1}, 18'h2_0000);
      chk("zero_alarm_ovf", n_ovf1 - snap_o1, 1);
      chk("zero_alarm_d0", {alm0, min0, sec0}, 17'h0_0200);

      // mid-run asynchronous reset
      cmd(0, 0, 1);
      alarm_en = 1'b0;
      cmd(1, 0, 0);
      ticks(17);
      chk("pre_reset", {run0, min0, sec0}, 17'h1_0017);
      rst_n = 1'b0;
      #1;
      chk("async_reset", {run0, alm0, tick0, ovf0, min0, sec0}, 20'h0_0000);
      cyc(2);
      rst_n = 1'b1;
      cyc(5);
      ticks(2);
      chk("post_reset_idle", {run0, min0, sec0}, 17'h0_0000);
      cmd(1, 0, 0);
      one_tick();
      chk("post_reset_count", {min0, sec0}, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
